// File: rtl/uart_boot_loader.sv
`timescale 1ns/1ps
// uart_boot_loader
//
// Receives a program image over an 8N1 UART line and writes it word by word
// into instruction memory. The processor is held in reset until the whole
// image has arrived. It is then released and the loader ignores the line.
//
// Image format on the wire:
//   two bytes of word count N (little-endian), then 4*N bytes of instruction
//   words. Each word is sent little-endian.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-low
//   rx          UART serial input, idle high, LSB first
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write (ADDR_W bits)
//   imem_wdata  instruction word of the write
//   cpu_rst     active-high reset to the processor; low only once loaded
//   done        sticky, load completed successfully
//   error       sticky, framing error or oversize word count
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  // Memory capacity in words; the word count may equal it but not exceed it.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  // ---------------------------------------------------------------------
  // rx synchronizer (idle level is high, so the flops reset to 1)
  // ---------------------------------------------------------------------
  logic rx_p0;
  logic rx_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // ---------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid;
  logic             frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  // The shift register holds no state the FSM depends on, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_p1) rx_state_d = RX_START;
      end
      RX_START: begin
        // Re-sample mid start bit; a high level means it was only a glitch.
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_p1 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == BIT_M1) begin
          bit_cnt_d = '0;
          shift_d   = {rx_p1, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == BIT_M1) begin
          bit_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_p1) byte_valid = 1'b1;
          else       frame_err  = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    L_CNT_LO,
    L_CNT_HI,
    L_DATA,
    L_WRITE,
    L_DONE,
    L_ERR
  } ld_state_t;

  ld_state_t         ld_state_q, ld_state_d;
  logic [ADDR_W:0]   n_words_q, n_words_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        n_lo_q, n_lo_d;
  logic [23:0]       word_q, word_d;
  logic              imem_we_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic [31:0]       imem_wdata_d;
  logic              cpu_rst_d;
  logic              done_d;
  logic              error_d;
  logic [16:0]       n_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_q <= L_CNT_LO;
      n_words_q  <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      n_words_q  <= n_words_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_rst    <= cpu_rst_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // Partial count / word bytes; always overwritten before being consumed.
  always_ff @(posedge clk) begin
    n_lo_q <= n_lo_d;
    word_q <= word_d;
  end

  always_comb begin
    ld_state_d   = ld_state_q;
    n_words_d    = n_words_q;
    word_cnt_d   = word_cnt_q;
    byte_idx_d   = byte_idx_q;
    n_lo_d       = n_lo_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    cpu_rst_d    = cpu_rst;
    done_d       = done;
    error_d      = error;
    n_ext        = {1'b0, shift_q, n_lo_q};
    case (ld_state_q)
      L_CNT_LO: begin
        if (frame_err) begin
          ld_state_d = L_ERR;
          error_d    = 1'b1;
        end else if (byte_valid) begin
          n_lo_d     = shift_q;
          ld_state_d = L_CNT_HI;
        end
      end
      L_CNT_HI: begin
        if (frame_err) begin
          ld_state_d = L_ERR;
          error_d    = 1'b1;
        end else if (byte_valid) begin
          if (n_ext == '0) begin
            ld_state_d = L_DONE;
            done_d     = 1'b1;
            cpu_rst_d  = 1'b0;
          end else if (n_ext > MAX_WORDS) begin
            ld_state_d = L_ERR;
            error_d    = 1'b1;
          end else begin
            ld_state_d  = L_DATA;
            n_words_d   = n_ext[ADDR_W:0];
            word_cnt_d  = '0;
            byte_idx_d  = '0;
            imem_addr_d = '0;
          end
        end
      end
      L_DATA: begin
        if (frame_err) begin
          ld_state_d = L_ERR;
          error_d    = 1'b1;
        end else if (byte_valid) begin
          // Bytes shift in from the top, so after three bytes word_q holds
          // {b2, b1, b0} and the fourth byte lands in bits [31:24].
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_wdata_d = {shift_q, word_q};
            imem_we_d    = 1'b1;
            ld_state_d   = L_WRITE;
          end else begin
            word_d = {shift_q, word_q[23:8]};
          end
        end
      end
      L_WRITE: begin
        // Strobe is high during this state; step the counters behind it.
        // The address does not advance past the final word, so it never wraps.
        word_cnt_d = word_cnt_q + 1'b1;
        if (frame_err) begin
          ld_state_d = L_ERR;
          error_d    = 1'b1;
        end else if (word_cnt_q + 1'b1 == n_words_q) begin
          ld_state_d = L_DONE;
          done_d     = 1'b1;
          cpu_rst_d  = 1'b0;
        end else begin
          imem_addr_d = imem_addr + 1'b1;
          ld_state_d  = L_DATA;
        end
      end
      L_DONE: ld_state_d = L_DONE;
      L_ERR:  ld_state_d = L_ERR;
      default: ld_state_d = L_ERR;
    endcase
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Loads a program image over a UART serial line into instruction memory before the core runs.
- Acts as the serial receiver end of the host-to-board download link, replacing the simulation-only memory-file preload.
- Holds `single_cycle_processor` in reset while loading, then releases it.
- Sits between the board RX pin, the instruction-memory write port and the processor reset input.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- rx  in  1  UART serial input, idle high, 8N1, LSB first.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word for the write.
- cpu_rst  out  1  active-high reset to the processor.
- done  out  1  load completed successfully; sticky.
- error  out  1  framing or size error; sticky.

Behaviour:
- Reset (rst=0, asynchronous): imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, error=0; both FSMs return to their idle state; any partial byte or word is discarded.
- rx passes through a 2-flop synchronizer before any use. Flops reset to 1.
- RX FSM states and transitions:
  - IDLE: waits for synchronized rx=0.
  - START: counts CLKS_PER_BIT/2 cycles, then re-samples. If rx=1 it was a glitch; return to IDLE with no byte.
  - DATA: samples 8 bits, each CLKS_PER_BIT cycles apart, shifting in LSB first.
  - STOP: samples after CLKS_PER_BIT cycles. If rx=1, pulse byte_valid for 1 cycle. If rx=0, raise a frame error.
  - After STOP, the FSM returns to IDLE.
- Loader FSM consumes byte_valid:
  - CNT_LO: byte becomes N[7:0].
  - CNT_HI: byte becomes N[15:8], giving a 16-bit little-endian word count N.
  - If N=0: go to DONE next cycle.
  - If N > 2^ADDR_W: go to ERR.
  - Otherwise: go to DATA.
  - DATA: bytes assemble little-endian (first byte = bits [7:0]); a 2-bit byte index wraps 3->0.
  - On the 4th byte of a word: in the next cycle imem_we=1 for exactly 1 cycle, imem_wdata = the assembled word, imem_addr = the word index (starting at 0).
  - imem_addr increments the cycle after the write. After the write that brings the word counter to N, enter DONE the following cycle.
  - DONE: done=1, cpu_rst=0, both registered in the same cycle. All further rx traffic is ignored; no writes occur.
  - ERR: entered on a frame error in any loader state before DONE, or on an oversize N. error=1, cpu_rst stays 1, no further writes. Leaves only via rst.
- imem_addr wrap: cannot occur, because N <= 2^ADDR_W is enforced; the last address is 2^ADDR_W-1.
- A byte arriving while a write strobe is pending is impossible, since the minimum byte spacing is 10*CLKS_PER_BIT cycles. No buffering is required.
- Reset mid-load: outputs return to their reset values immediately. A new load must start from CNT_LO; memory contents are left as-is.
- done and error are mutually exclusive.
- Total load latency ≈ (2 + 4N) * 10 * CLKS_PER_BIT cycles + 2 cycles.

Test Plan (CLKS_PER_BIT=4, ADDR_W=4):
- Send 02 00 13 05 50 00 93 05 10 00 -> writes addr0=0x00500513, then addr1=0x00100593. Each imem_we is exactly 1 cycle wide. done=1 and cpu_rst=0 one cycle after the 2nd write.
- Send 00 00 -> no imem_we. done=1 and cpu_rst=0 after the second byte's stop bit. Further bytes produce no writes.
- Send count 11 00 (17 > 16) -> error=1, cpu_rst=1, done=0, no writes.
- Send count 01 00, then a byte whose stop bit is held low -> error=1, no write, cpu_rst stays 1.
- Drive rx low for 1 cycle only (glitch), then send 01 00 EF BE AD DE -> glitch ignored; single write addr0=0xDEADBEEF, then done=1.
- Assert rst low in the middle of the 3rd data byte of a 2-word load -> outputs return to reset values asynchronously. After release, a fresh 01 00 78 56 34 12 load writes addr0=0x12345678 and done=1.
